// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage.
// Holds the fetch FSM state type, the reset vector, the bubble instruction
// and the default ROM window size.
package fetch_pkg;

  localparam int unsigned A_WIDTH_C   = 32;
  localparam int unsigned I_WIDTH_C   = 32;
  localparam int unsigned ROM_BYTES_C = 4096;

  localparam logic [31:0] RESET_VECTOR_C = 32'hBFC0_0000;
  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_C    = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         load a bubble (wins over stall_i)
//   stall_i         hold current contents
//   instr_i/pc_i/pc_plus4_i  fetched word and its PCs, captured on a load
//   instr_o/pc_o/pc_plus4_o/valid_o  registered IF/ID contents
// A bubble replaces the instruction with NOP and clears valid, but keeps the
// PC fields so downstream debug/trace still sees the last real PC.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned        A_WIDTH   = A_WIDTH_C,
  parameter int unsigned        I_WIDTH   = I_WIDTH_C,
  parameter logic [I_WIDTH-1:0] NOP_INSTR = I_WIDTH'(NOP_INSTR_C)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic [I_WIDTH-1:0] instr_i,
  input  logic [A_WIDTH-1:0] pc_i,
  input  logic [A_WIDTH-1:0] pc_plus4_i,
  output logic [I_WIDTH-1:0] instr_o,
  output logic [A_WIDTH-1:0] pc_o,
  output logic [A_WIDTH-1:0] pc_plus4_o,
  output logic               valid_o
);

  logic [I_WIDTH-1:0] instr_q, instr_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic [A_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;

  // Next-state: flush > stall > load
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined RV32I core.
// Owns the PC, drives the combinational instruction ROM address and fills
// the IF/ID register. Fetches outside the ROM window park the stage in FAULT
// until execute redirects it.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   imem_addr / imem_rd        ROM address (= PC) and same-cycle read data
//   stall_f, stall_d, flush_d  hazard-unit controls
//   redirect_e, redirect_pc_e  taken branch/jump from execute
//   instr_d, pc_d, pc_plus4_d, valid_d  IF/ID contents
//   misalign_d                 one-cycle pulse after a misaligned redirect
//   fault                      stage is in FAULT
// Optional: define FETCH_PERF_EN to add perf_fetched/perf_stalled/
// perf_flushed saturating event counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned        A_WIDTH      = A_WIDTH_C,
  parameter int unsigned        I_WIDTH      = I_WIDTH_C,
  parameter logic [A_WIDTH-1:0] RESET_VECTOR = A_WIDTH'(RESET_VECTOR_C),
  parameter int unsigned        ROM_BYTES    = ROM_BYTES_C,
  parameter logic [I_WIDTH-1:0] NOP_INSTR    = I_WIDTH'(NOP_INSTR_C)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic [I_WIDTH-1:0] imem_rd,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               redirect_e,
  input  logic [A_WIDTH-1:0] redirect_pc_e,
  output logic [I_WIDTH-1:0] instr_d,
  output logic [A_WIDTH-1:0] pc_d,
  output logic [A_WIDTH-1:0] pc_plus4_d,
  output logic               valid_d,
  output logic               misalign_d,
  output logic               fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalled,
  output logic [31:0]        perf_flushed
`endif
);

  // Address of the last word in the ROM window
  localparam logic [A_WIDTH-1:0] ROM_LAST = RESET_VECTOR + A_WIDTH'(ROM_BYTES - 32'd4);

  fetch_state_t       state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_nxt;
  logic [A_WIDTH-1:0] pc_plus4;
  logic               misalign_pulse_q, misalign_pulse_d;
  logic               in_range;
  logic               force_bubble;
  logic               if_id_flush;

  assign pc_plus4  = pc_q + A_WIDTH'(4);
  assign in_range  = (pc_q >= RESET_VECTOR) && (pc_q <= ROM_LAST);
  assign imem_addr = pc_q;

  // Next state / next PC; redirect is applied last so it beats every hold
  always_comb begin
    state_d      = state_q;
    pc_nxt       = pc_q;
    force_bubble = 1'b0;
    case (state_q)
      BOOT: begin
        force_bubble = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (!in_range) begin
          // Never capture data from outside the ROM window
          force_bubble = 1'b1;
          if (!redirect_e) state_d = FAULT;
        end else if (!stall_f) begin
          pc_nxt = pc_plus4;
        end
      end
      FAULT: begin
        force_bubble = 1'b1;
        if (redirect_e) state_d = RUN;
      end
      default: begin
        force_bubble = 1'b1;
        state_d      = BOOT;
      end
    endcase
    if (redirect_e) begin
      pc_nxt = {redirect_pc_e[A_WIDTH-1:2], 2'b00};
    end
    misalign_pulse_d = redirect_e && (redirect_pc_e[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= BOOT;
      pc_q             <= RESET_VECTOR;
      misalign_pulse_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_nxt;
      misalign_pulse_q <= misalign_pulse_d;
    end
  end

  assign if_id_flush = flush_d || force_bubble;

  if_id_reg #(
    .A_WIDTH   (A_WIDTH),
    .I_WIDTH   (I_WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (if_id_flush),
    .stall_i    (stall_d),
    .instr_i    (imem_rd),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_o    (instr_d),
    .pc_o       (pc_d),
    .pc_plus4_o (pc_plus4_d),
    .valid_o    (valid_d)
  );

  assign misalign_d = misalign_pulse_q;
  assign fault      = (state_q == FAULT);

`ifdef FETCH_PERF_EN
  localparam int unsigned PERF_W = 32;

  logic              load_fire;
  logic [PERF_W-1:0] fetched_q, stalled_q, flushed_q;

  assign load_fire = !if_id_flush && !stall_d;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stalled_q <= '0;
      flushed_q <= '0;
    end else begin
      if (load_fire && (fetched_q != '1)) fetched_q <= fetched_q + PERF_W'(1);
      if (stall_f && (stalled_q != '1))   stalled_q <= stalled_q + PERF_W'(1);
      if (flush_d && (flushed_q != '1))   flushed_q <= flushed_q + PERF_W'(1);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalled = stalled_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random hazard
// traffic, every cycle compared against a behavioural model of the stage.
module tb_fetch_stage;

  localparam logic [31:0] RV      = 32'hBFC0_0000;
  localparam logic [31:0] RV_LAST = 32'hBFC0_0FFC;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall_f, stall_d, flush_d, redirect_e;
  logic [31:0] redirect_pc_e, imem_addr, imem_rd, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, misalign_d, fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalled, perf_flushed;
  logic [31:0] c_fetched, c_stalled, c_flushed;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] rom [0:1023];

  // Model state
  logic [31:0] m_pc, e_instr, e_pc, e_pc4;
  logic        m_boot, m_fault, e_valid, e_mis;
  logic [31:0] saved;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .redirect_e    (redirect_e),
    .redirect_pc_e (redirect_pc_e),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .pc_plus4_d    (pc_plus4_d),
    .valid_d       (valid_d),
    .misalign_d    (misalign_d),
    .fault         (fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stalled  (perf_stalled),
    .perf_flushed  (perf_flushed)
`endif
  );

  function automatic logic in_window(input logic [31:0] a);
    return (a >= RV) && (a <= RV_LAST);
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return rom[10'((a - RV) >> 2)];
  endfunction

  // Combinational ROM; garbage outside the window must never be captured
  always_comb begin
    if (in_window(imem_addr)) imem_rd = rom_word(imem_addr);
    else                      imem_rd = 32'hDEAD_BEEF;
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic model_edge();
    logic rng, bub;
    if (rst) begin
      m_pc = RV; m_boot = 1'b1; m_fault = 1'b0;
      e_instr = NOP; e_pc = '0; e_pc4 = '0; e_valid = 1'b0; e_mis = 1'b0;
`ifdef FETCH_PERF_EN
      c_fetched = '0; c_stalled = '0; c_flushed = '0;
`endif
    end else begin
      rng = in_window(m_pc);
      bub = flush_d || m_boot || m_fault || !rng;
      if (bub) begin
        e_instr = NOP;
        e_valid = 1'b0;
      end else if (!stall_d) begin
        e_instr = rom_word(m_pc);
        e_pc    = m_pc;
        e_pc4   = m_pc + 32'd4;
        e_valid = 1'b1;
      end
`ifdef FETCH_PERF_EN
      if (!bub && !stall_d) c_fetched = sat_inc(c_fetched);
      if (stall_f)          c_stalled = sat_inc(c_stalled);
      if (flush_d)          c_flushed = sat_inc(c_flushed);
`endif
      e_mis = redirect_e && (redirect_pc_e[1:0] != 2'b00);
      if (redirect_e) begin
        m_pc = redirect_pc_e & 32'hFFFF_FFFC;
        m_boot = 1'b0;
        m_fault = 1'b0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_fault) begin
        if (!rng)          m_fault = 1'b1;
        else if (!stall_f) m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    check("imem_addr",  imem_addr,  m_pc);
    check("instr_d",    instr_d,    e_instr);
    check("pc_d",       pc_d,       e_pc);
    check("pc_plus4_d", pc_plus4_d, e_pc4);
    check("valid_d",    32'(valid_d),    32'(e_valid));
    check("misalign_d", 32'(misalign_d), 32'(e_mis));
    check("fault",      32'(fault),      32'(m_fault));
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, c_fetched);
    check("perf_stalled", perf_stalled, c_stalled);
    check("perf_flushed", perf_flushed, c_flushed);
`endif
  endtask

  task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                      input logic re, input logic [31:0] rpc);
    rst = r; stall_f = sf; stall_d = sd; flush_d = fd;
    redirect_e = re; redirect_pc_e = rpc;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    redirect_e = 1'b0; redirect_pc_e = '0;

`ifdef FETCH_PERF_EN
    // 10 fetches, 2 stalls, 1 flush
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("perf_fetched_10", perf_fetched, 32'd10);
    check("perf_stalled_2",  perf_stalled, 32'd2);
    check("perf_flushed_1",  perf_flushed, 32'd1);
    step(1, 0, 0, 0, 0, 0);
    check("perf_clear_f", perf_fetched, 32'd0);
    check("perf_clear_s", perf_stalled, 32'd0);
    check("perf_clear_x", perf_flushed, 32'd0);
`endif

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_addr",  imem_addr, RV);
    check("rst_instr", instr_d, NOP);
    check("rst_valid", 32'(valid_d), 32'd0);

    // BOOT then sequential RUN
    step(0, 0, 0, 0, 0, 0);
    check("boot_addr", imem_addr, 32'hBFC0_0000);
    step(0, 0, 0, 0, 0, 0);
    check("run_addr4",   imem_addr, 32'hBFC0_0004);
    check("first_instr", instr_d, rom[0]);
    check("first_valid", 32'(valid_d), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check("run_addr8", imem_addr, 32'hBFC0_0008);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("pre_stall_addr", imem_addr, 32'hBFC0_0010);

    // Stall PC and IF/ID for 3 cycles
    saved = instr_d;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 0);
      check("stall_addr",  imem_addr, 32'hBFC0_0010);
      check("stall_instr", instr_d, saved);
    end
    step(0, 0, 0, 0, 0, 0);
    check("post_stall_instr", instr_d, rom[4]);

    // Redirect beats stall_f; hazard unit flushes alongside
    step(0, 1, 0, 1, 1, 32'hBFC0_0100);
    check("redir_addr",  imem_addr, 32'hBFC0_0100);
    check("redir_valid", 32'(valid_d), 32'd0);
    check("redir_instr", instr_d, NOP);

    // Misaligned redirect
    step(0, 0, 0, 1, 1, 32'hBFC0_0203);
    check("mis_addr",  imem_addr, 32'hBFC0_0200);
    check("mis_pulse", 32'(misalign_d), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check("mis_clear", 32'(misalign_d), 32'd0);

    // Run off the end of the ROM window
    step(0, 0, 0, 1, 1, 32'hBFC0_0FF8);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("last_instr", instr_d, rom[1023]);
    step(0, 0, 0, 0, 0, 0);
    check("fault_on",    32'(fault), 32'd1);
    check("fault_addr",  imem_addr, 32'hBFC0_1000);
    check("fault_valid", 32'(valid_d), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("fault_hold", imem_addr, 32'hBFC0_1000);
    step(0, 0, 0, 1, 1, 32'hBFC0_0000);
    check("fault_exit",      32'(fault), 32'd0);
    check("fault_exit_addr", imem_addr, 32'hBFC0_0000);

    // Reset while in FAULT
    step(0, 0, 0, 1, 1, 32'h0000_0000);
    step(0, 0, 0, 0, 0, 0);
    check("fault_again", 32'(fault), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    check("fault_rst",      32'(fault), 32'd0);
    check("fault_rst_addr", imem_addr, RV);

    // Random hazard traffic
    for (int i = 0; i < 600; i++) begin
      logic r, sf, sd, fd, re;
      logic [31:0] t;
      int unsigned sel;
      r   = ($urandom_range(63) == 0);
      sf  = ($urandom_range(5) == 0);
      sd  = ($urandom_range(5) == 0);
      re  = ($urandom_range(11) == 0);
      fd  = re || ($urandom_range(9) == 0);
      sel = $urandom_range(3);
      case (sel)
        0, 1:    t = RV + 32'($urandom_range(4095));
        2:       t = RV + 32'h0000_0FE0 + 32'($urandom_range(31));
        default: t = $urandom;
      endcase
      step(r, sf, sd, fd, re, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
